state_predict_seq: RTL

- Sequential, parametrised successor to the combinational PMSM EKF state-prediction stage.
- Computes the one-step prediction (ialphae, ibetae, omegae, thetae) and the 4x4 Jacobian F and its transpose with one shared Q-format multiplier, driven by an FSM.
- Adds start/ready/valid handshake, saturating state arithmetic with a sticky overflow flag, and theta wrap into [-pi, pi).
- Sits between the sin/cos generator and the covariance-update block.

---
 rtl/state_predict_seq.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/state_predict_seq.sv
// PMSM EKF one-step state prediction and Jacobian, computed serially through one shared Q-format multiplier.
// Latency 11+MUL_LAT cycles from accept to out_valid. start is taken only while in_ready (IDLE); a busy start is dropped, not queued.
module state_predict_seq #(
  parameter int N            = 32,
  parameter int Q            = 18,
  parameter int MUL_LAT      = 1,
  parameter int TS_LS        = 124,
  parameter int RS_TS_LS     = 184,
  parameter int LAMBDA_TS_LS = 25,
  parameter int T_Q          = 3,
  parameter int PI_Q         = 823550
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                in_ready,
  input  logic signed [N-1:0] ialpha,
  input  logic signed [N-1:0] ibeta,
  input  logic signed [N-1:0] valpha,
  input  logic signed [N-1:0] vbeta,
  input  logic signed [N-1:0] omega,
  input  logic signed [N-1:0] theta,
  input  logic signed [N-1:0] stheta,
  input  logic signed [N-1:0] ctheta,
  input  logic                clear_ovf,
  output logic                out_valid,
  output logic signed [N-1:0] ialphae,
  output logic signed [N-1:0] ibetae,
  output logic signed [N-1:0] omegae,
  output logic signed [N-1:0] thetae,
  output logic [16*N-1:0]     F,
  output logic [16*N-1:0]     F_transpose,
  output logic                ovf
);

  localparam logic signed [N-1:0] C_TS    = N'(TS_LS);
  localparam logic signed [N-1:0] C_RS    = N'(RS_TS_LS);
  localparam logic signed [N-1:0] C_LAM   = N'(LAMBDA_TS_LS);
  localparam logic signed [N-1:0] C_TQ    = N'(T_Q);
  localparam logic signed [N-1:0] C_SF    = N'(2**Q);
  localparam logic signed [N-1:0] C_F00   = N'(2**Q - RS_TS_LS);
  localparam logic signed [N-1:0] C_PI    = N'(PI_Q);
  localparam logic signed [N-1:0] C_NPI   = N'(-PI_Q);
  localparam logic signed [N-1:0] C_2PI   = N'(2 * PI_Q);
  localparam logic signed [N-1:0] C_MAX   = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] C_MIN   = {1'b1, {(N-1){1'b0}}};
  localparam logic [3:0]          C_ISSUE_LAST = 4'd8;
  localparam logic [3:0]          C_DRAIN_LAST = 4'(MUL_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_SUM, S_WRAP} state_t;

  state_t r_state, w_state_nxt;
  logic [3:0] r_cnt;
  logic       w_issue;

  logic signed [N-1:0] r_ia, r_ib, r_va, r_vb, r_om, r_th, r_st, r_ct;
  logic signed [N-1:0] r_p [9];

  logic signed [N-1:0]   w_a, w_b, w_prod;
  logic [3:0]            w_idx;
  logic signed [2*N-1:0] w_full, w_shift;
  logic                  w_mul_sat;

  logic                r_pv   [MUL_LAT];
  logic [3:0]          r_pidx [MUL_LAT];
  logic signed [N-1:0] r_pval [MUL_LAT];

  logic signed [N+2:0] w_sum_a, w_sum_b, w_sum_t;
  logic signed [N-1:0] w_theta_c, w_theta_w;
  logic signed [N-1:0] w_fe [16];
  logic [16*N-1:0]     w_f, w_ft;
  logic                w_ovf_set;

  logic signed [N-1:0] r_ialphae, r_ibetae, r_omegae, r_thetae;
  logic [16*N-1:0]     r_f, r_ft;
  logic                r_ovf;

  function automatic logic signed [N+2:0] sx(input logic signed [N-1:0] v);
    return {{3{v[N-1]}}, v};
  endfunction

  function automatic logic fits(input logic signed [N+2:0] v);
    return (&v[N+2:N-1]) | ~(|v[N+2:N-1]);
  endfunction

  function automatic logic signed [N-1:0] clamp(input logic signed [N+2:0] v);
    if (fits(v)) return v[N-1:0];
    return v[N+2] ? C_MIN : C_MAX;
  endfunction

  // FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (w_state_nxt != r_state) ? 4'd0 : r_cnt + 4'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        w_issue = 1'b1;
        if (r_cnt == C_ISSUE_LAST) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: if (r_cnt == C_DRAIN_LAST) w_state_nxt = S_SUM;
      S_SUM:   w_state_nxt = S_WRAP;
      S_WRAP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ia <= '0; r_ib <= '0; r_va <= '0; r_vb <= '0;
      r_om <= '0; r_th <= '0; r_st <= '0; r_ct <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_ia <= ialpha; r_ib <= ibeta;  r_va <= valpha; r_vb <= vbeta;
      r_om <= omega;  r_th <= theta;  r_st <= stheta; r_ct <= ctheta;
    end
  end

  // p2/p6 go first so p3/p7 can reuse them from r_p by issue slots 7 and 8
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_idx = '0;
    case (r_cnt)
      4'd0: begin w_a = r_st; w_b = C_LAM;  w_idx = 4'd2; end
      4'd1: begin w_a = r_ct; w_b = C_LAM;  w_idx = 4'd6; end
      4'd2: begin w_a = r_va; w_b = C_TS;   w_idx = 4'd0; end
      4'd3: begin w_a = r_ia; w_b = C_RS;   w_idx = 4'd1; end
      4'd4: begin w_a = r_vb; w_b = C_TS;   w_idx = 4'd4; end
      4'd5: begin w_a = r_ib; w_b = C_RS;   w_idx = 4'd5; end
      4'd6: begin w_a = r_om; w_b = C_TQ;   w_idx = 4'd8; end
      4'd7: begin w_a = r_om; w_b = r_p[2]; w_idx = 4'd3; end
      4'd8: begin w_a = r_om; w_b = r_p[6]; w_idx = 4'd7; end
      default: ;
    endcase
  end

  assign w_full    = $signed({{N{w_a[N-1]}}, w_a}) * $signed({{N{w_b[N-1]}}, w_b});
  assign w_shift   = w_full >>> Q;
  assign w_mul_sat = ~((&w_shift[2*N-1:N-1]) | ~(|w_shift[2*N-1:N-1]));
  assign w_prod    = w_mul_sat ? (w_shift[2*N-1] ? C_MIN : C_MAX) : w_shift[N-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        r_pv[i]   <= 1'b0;
        r_pidx[i] <= '0;
        r_pval[i] <= '0;
      end
    end else begin
      r_pv[0]   <= w_issue;
      r_pidx[0] <= w_idx;
      r_pval[0] <= w_prod;
      for (int i = 1; i < MUL_LAT; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_pidx[i] <= r_pidx[i-1];
        r_pval[i] <= r_pval[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) r_p[i] <= '0;
    end else if (r_pv[MUL_LAT-1]) begin
      r_p[r_pidx[MUL_LAT-1]] <= r_pval[MUL_LAT-1];
    end
  end

  assign w_sum_a   = sx(r_ia) + sx(r_p[0]) - sx(r_p[1]) + sx(r_p[3]);
  assign w_sum_b   = sx(r_ib) + sx(r_p[4]) - sx(r_p[5]) - sx(r_p[7]);
  assign w_sum_t   = sx(r_th) + sx(r_p[8]);
  assign w_theta_c = clamp(w_sum_t);

  // One correction only; PI_Q is far below full scale so neither branch can overflow N bits
  always_comb begin
    w_theta_w = w_theta_c;
    if (w_theta_c >= C_PI)       w_theta_w = w_theta_c - C_2PI;
    else if (w_theta_c < C_NPI)  w_theta_w = w_theta_c + C_2PI;
  end

  always_comb begin
    for (int i = 0; i < 16; i++) w_fe[i] = '0;
    w_fe[0]  = C_F00;
    w_fe[2]  = r_p[2];
    w_fe[3]  = r_p[7];
    w_fe[5]  = C_F00;
    w_fe[6]  = -r_p[6];
    w_fe[7]  = r_p[3];
    w_fe[10] = C_SF;
    w_fe[14] = C_TQ;
    w_fe[15] = C_SF;
    w_f  = '0;
    w_ft = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_f[(4*r+c)*N +: N]  = w_fe[4*r+c];
        w_ft[(4*r+c)*N +: N] = w_fe[4*c+r];
      end
    end
  end

  // Results land on the SUM->WRAP edge so they are stable during the out_valid cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ialphae <= '0;
      r_ibetae  <= '0;
      r_omegae  <= '0;
      r_thetae  <= '0;
      r_f       <= '0;
      r_ft      <= '0;
    end else if (r_state == S_SUM) begin
      r_ialphae <= clamp(w_sum_a);
      r_ibetae  <= clamp(w_sum_b);
      r_omegae  <= r_om;
      r_thetae  <= w_theta_w;
      r_f       <= w_f;
      r_ft      <= w_ft;
    end
  end

  assign w_ovf_set = (w_issue && w_mul_sat) ||
                     ((r_state == S_SUM) && (!fits(w_sum_a) || !fits(w_sum_b) || !fits(w_sum_t)));

  always_ff @(posedge clk) begin
    if (reset) r_ovf <= 1'b0;
    else       r_ovf <= w_ovf_set | (r_ovf & ~clear_ovf);
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_WRAP);
  assign ialphae     = r_ialphae;
  assign ibetae      = r_ibetae;
  assign omegae      = r_omegae;
  assign thetae      = r_thetae;
  assign F           = r_f;
  assign F_transpose = r_ft;
  assign ovf         = r_ovf;

endmodule
